if_pc_fetch: RTL
================

Name: if_pc_fetch

Overview:
- Instruction-fetch front end of the RISC-V core: owns the program counter and issues one instruction-memory request at a time.
- Presents each fetched instruction to decode over a valid/ready handshake.
- Drives the operands of the external 32-bit PC adder (pc, 4) and consumes its sum as the sequential next PC.
- Accepts a redirect from execute for taken branches and jumps.

Parameters:
- XLEN, 32, datapath and address width.
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- INSTR_BYTES, 4, constant driven on add_b (PC increment).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset.
- add_a  out  XLEN  adder operand A; always equals pc.
- add_b  out  XLEN  adder operand B; constant INSTR_BYTES.
- add_sum  in  XLEN  adder result (pc+4), combinational from add_a/add_b.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts request.
- imem_addr  out  XLEN  request address; equals pc.
- imem_rsp_valid  in  1  response valid; 1-cycle pulse, any latency >=1 cycle after accept.
- imem_rsp_data  in  XLEN  instruction word.
- redirect_valid  in  1  branch/jump taken, 1-cycle pulse.
- redirect_pc  in  XLEN  redirect target.
- if_valid  out  1  instruction available to decode.
- if_ready  in  1  decode accepts.
- if_pc  out  XLEN  PC of presented instruction.
- if_instr  out  XLEN  presented instruction.

Behaviour:
- Reset (rst_n=0 sampled at clk edge), regardless of state or in-flight transfer:
  - pc=RESET_PC, state=S_REQ, drop=0.
  - Outputs: if_valid=0, if_pc=0, if_instr=0, imem_req_valid=0 during reset.
  - Any response arriving after reset is ignored unless a new request has been accepted.
- add_a=pc and add_b=INSTR_BYTES, combinational, in every state.
- FSM states S_REQ, S_WAIT, S_FULL; at most one request outstanding.
- S_REQ:
  - imem_req_valid = !redirect_valid; imem_addr = pc.
  - redirect_valid: pc<=redirect_pc, stay S_REQ, no request issued this cycle.
  - Else if imem_req_ready: go S_WAIT.
- S_WAIT:
  - imem_req_valid=0.
  - On imem_rsp_valid with drop=0 and no redirect: capture if_instr<=imem_rsp_data, if_pc<=pc, go S_FULL.
  - redirect_valid without rsp_valid: pc<=redirect_pc, drop<=1, stay S_WAIT.
  - rsp_valid with drop=1: discard response, drop<=0, go S_REQ.
  - redirect_valid and rsp_valid in the same cycle: response discarded, pc<=redirect_pc, drop stays 0, go S_REQ.
- S_FULL:
  - if_valid=1; if_pc/if_instr held stable until handshake.
  - if_valid&&if_ready: pc<=add_sum, go S_REQ.
  - redirect_valid takes priority over the handshake: pc<=redirect_pc, if_valid drops next cycle, go S_REQ; the presented instruction is squashed even if if_ready=1.
- Latency:
  - Request issues the cycle after handshake or redirect.
  - if_valid asserts the cycle after imem_rsp_valid.
  - Minimum fetch throughput: one instruction per 3 cycles with a 1-cycle memory.
- PC wrap: add_sum overflow 32'hFFFF_FFFC+4=0 wraps modulo 2^XLEN, no flag.
- redirect_pc[1:0] is handled per the optional feature.

Optional Feature:
- Macro IF_MISALIGN_CHK_EN.
- Defined:
  - Extra output misalign_err (1 bit, reset 0).
  - redirect_pc[1:0]!=0 sets misalign_err sticky until reset.
  - pc loads redirect_pc unmodified.
  - The block stays in S_REQ with imem_req_valid=0 until reset.
- Undefined:
  - No port.
  - pc loads {redirect_pc[XLEN-1:2],2'b00} silently.

Test Plan:
- Reset, then sequential fetch, imem 1-cycle latency, if_ready=1 -> requests at 0x0, 0x4, 0x8; if_pc/if_instr match memory; add_a tracks pc, add_b=4.
- Backpressure: if_ready=0 for 5 cycles with if_valid=1 -> if_pc=0x4 and if_instr stable; no new request until the handshake.
- Redirect in S_WAIT to 0x100, response 3 cycles later -> response dropped, next request at 0x100, no if_valid for the stale word.
- Redirect and rsp_valid in the same cycle, redirect_pc=0x200 -> no if_valid; next imem_addr=0x200.
- Wrap: redirect to 0xFFFF_FFFC, handshake -> next imem_addr=0x0000_0000.
- rst_n=0 asserted in S_FULL -> next cycle if_valid=0, pc=RESET_PC; late response ignored. With IF_MISALIGN_CHK_EN: redirect_pc=0x102 -> misalign_err=1, no further requests.

Source files
------------

// File: rtl/if_pc_fetch.sv
// Instruction-fetch front end: owns the PC, keeps one imem request in flight, hands words to decode.
// Optional build macro IF_MISALIGN_CHK_EN adds a sticky misaligned-redirect error that halts fetch.
module if_pc_fetch #(
  parameter int unsigned     XLEN        = 32,
  parameter logic [XLEN-1:0] RESET_PC    = '0,
  parameter int unsigned     INSTR_BYTES = 4
) (
  input  logic            clk,
  input  logic            rst_n,
`ifdef IF_MISALIGN_CHK_EN
  output logic            misalign_err,
`endif
  output logic [XLEN-1:0] add_a,
  output logic [XLEN-1:0] add_b,
  input  logic [XLEN-1:0] add_sum,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            if_valid,
  input  logic            if_ready,
  output logic [XLEN-1:0] if_pc,
  output logic [XLEN-1:0] if_instr
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_FULL = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_next;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] w_pc_next;
  logic            r_drop;
  logic            w_drop_next;
  logic [XLEN-1:0] r_if_pc;
  logic [XLEN-1:0] r_if_instr;
  logic            w_capture;
  logic            w_req_valid;
  logic            w_if_valid;
  logic [XLEN-1:0] w_redirect_pc;
  logic            w_misalign_set;
  logic            w_halt;

`ifdef IF_MISALIGN_CHK_EN
  logic r_misalign_err;

  assign w_redirect_pc  = redirect_pc;
  assign w_misalign_set = redirect_valid && (redirect_pc[1:0] != 2'b00);
  assign w_halt         = r_misalign_err;
  assign misalign_err   = r_misalign_err;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_misalign_err <= 1'b0;
    end else if (w_misalign_set) begin
      r_misalign_err <= 1'b1;
    end
  end
`else
  // Low address bits are silently forced to a word boundary.
  assign w_redirect_pc  = redirect_pc & ~XLEN'(3);
  assign w_misalign_set = 1'b0;
  assign w_halt         = 1'b0;
`endif

  assign add_a     = r_pc;
  assign add_b     = XLEN'(INSTR_BYTES);
  assign imem_addr = r_pc;
  assign if_pc     = r_if_pc;
  assign if_instr  = r_if_instr;

  // Handshake outputs are forced low while reset is asserted, whatever the state register holds.
  assign imem_req_valid = w_req_valid && rst_n;
  assign if_valid       = w_if_valid && rst_n;

  always_comb begin
    w_state_next = r_state;
    w_pc_next    = r_pc;
    w_drop_next  = r_drop;
    w_capture    = 1'b0;
    w_req_valid  = 1'b0;
    w_if_valid   = 1'b0;

    case (r_state)
      S_REQ: begin
        w_req_valid = !redirect_valid && !w_halt;
        if (redirect_valid) begin
          w_pc_next = w_redirect_pc;
        end else if (imem_req_ready && !w_halt) begin
          w_state_next = S_WAIT;
        end
      end

      S_WAIT: begin
        if (imem_rsp_valid && redirect_valid) begin
          w_pc_next    = w_redirect_pc;
          w_drop_next  = 1'b0;
          w_state_next = S_REQ;
        end else if (imem_rsp_valid && r_drop) begin
          w_drop_next  = 1'b0;
          w_state_next = S_REQ;
        end else if (imem_rsp_valid) begin
          w_capture    = 1'b1;
          w_state_next = S_FULL;
        end else if (redirect_valid) begin
          // Request already in flight: remember to discard its response.
          w_pc_next   = w_redirect_pc;
          w_drop_next = 1'b1;
        end
      end

      S_FULL: begin
        w_if_valid = 1'b1;
        if (redirect_valid) begin
          w_pc_next    = w_redirect_pc;
          w_state_next = S_REQ;
        end else if (if_ready) begin
          w_pc_next    = add_sum;
          w_state_next = S_REQ;
        end
      end

      default: begin
        w_state_next = S_REQ;
      end
    endcase

    // A misaligned redirect parks the block in S_REQ; any in-flight response is ignored there.
    if (w_misalign_set) begin
      w_state_next = S_REQ;
      w_drop_next  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= S_REQ;
      r_pc       <= RESET_PC;
      r_drop     <= 1'b0;
      r_if_pc    <= '0;
      r_if_instr <= '0;
    end else begin
      r_state <= w_state_next;
      r_pc    <= w_pc_next;
      r_drop  <= w_drop_next;
      if (w_capture) begin
        r_if_pc    <= r_pc;
        r_if_instr <= imem_rsp_data;
      end
    end
  end

endmodule
